exe_stage: RTL and testbench

- Execute stage of the 5-stage ARM pipeline. Directly consumes the ID-stage pipeline register outputs.
- Applies forwarding muxes, generates the second operand (val2), runs the ALU and computes the branch target.
- Owns the NZCV status register and the EXE/MEM pipeline register feeding the memory stage.

---
 rtl/arm_pkg.sv | 29 ++
 rtl/val2_gen.sv | 41 ++++
 rtl/exe_stage.sv | 138 +++++++++++++
 tb/tb_exe_stage.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/arm_pkg.sv
// Shared ARM pipeline constants: ALU commands, shifter types, forwarding selects
// and NZCV bit positions.
package arm_pkg;

  localparam logic [3:0] EXE_MOV = 4'b0001;
  localparam logic [3:0] EXE_MVN = 4'b1001;
  localparam logic [3:0] EXE_ADD = 4'b0010;
  localparam logic [3:0] EXE_ADC = 4'b0011;
  localparam logic [3:0] EXE_SUB = 4'b0100;
  localparam logic [3:0] EXE_SBC = 4'b0101;
  localparam logic [3:0] EXE_AND = 4'b0110;
  localparam logic [3:0] EXE_ORR = 4'b0111;
  localparam logic [3:0] EXE_EOR = 4'b1000;

  localparam logic [1:0] SHIFT_LSL = 2'b00;
  localparam logic [1:0] SHIFT_LSR = 2'b01;
  localparam logic [1:0] SHIFT_ASR = 2'b10;
  localparam logic [1:0] SHIFT_ROR = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam int unsigned STAT_N = 3;
  localparam int unsigned STAT_Z = 2;
  localparam int unsigned STAT_C = 1;
  localparam int unsigned STAT_V = 0;

endpackage

// File: rtl/val2_gen.sv
// Combinational second-operand generator: memory offset, rotated immediate or
// shifted register.
module val2_gen
  import arm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] val_rm_i,
  input  logic [11:0]     shift_operand_i,
  input  logic            imm_i,
  input  logic            mem_i,
  output logic [XLEN-1:0] val2_o
);

  logic [4:0]        amt;
  logic [XLEN-1:0]   imm_ext;
  logic [2*XLEN-1:0] rot_imm;
  logic [2*XLEN-1:0] rot_reg;

  always_comb begin
    amt     = shift_operand_i[11:7];
    imm_ext = {{(XLEN-8){1'b0}}, shift_operand_i[7:0]};
    // Rotate by shifting a doubled copy; the low half is the rotated word.
    rot_imm = {imm_ext, imm_ext} >> {shift_operand_i[11:8], 1'b0};
    rot_reg = {val_rm_i, val_rm_i} >> amt;
    val2_o  = '0;
    if (mem_i) begin
      val2_o = {{(XLEN-12){1'b0}}, shift_operand_i};
    end else if (imm_i) begin
      val2_o = rot_imm[XLEN-1:0];
    end else begin
      case (shift_operand_i[6:5])
        SHIFT_LSL: val2_o = val_rm_i << amt;
        SHIFT_LSR: val2_o = val_rm_i >> amt;
        SHIFT_ASR: val2_o = $signed(val_rm_i) >>> amt;
        default:   val2_o = rot_reg[XLEN-1:0];
      endcase
    end
  end

endmodule

// File: rtl/exe_stage.sv
// ARM execute stage: forwarding muxes, ALU with NZCV flags, branch target and the
// EXE/MEM pipeline register.
module exe_stage
  import arm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            freeze,
  input  logic            wb_en_in,
  input  logic            mem_r_en_in,
  input  logic            mem_w_en_in,
  input  logic            b_in,
  input  logic            s_in,
  input  logic            imm_in,
  input  logic [3:0]      exe_cmd_in,
  input  logic [3:0]      dest_in,
  input  logic [11:0]     shift_operand_in,
  input  logic [23:0]     signed_imm_24_in,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] val_rn_in,
  input  logic [XLEN-1:0] val_rm_in,
  input  logic [1:0]      sel_src1,
  input  logic [1:0]      sel_src2,
  input  logic [XLEN-1:0] mem_fwd_val,
  input  logic [XLEN-1:0] wb_fwd_val,
  output logic            branch_taken,
  output logic [XLEN-1:0] branch_addr,
  output logic [3:0]      status,
  output logic            wb_en,
  output logic            mem_r_en,
  output logic            mem_w_en,
  output logic [XLEN-1:0] alu_res,
  output logic [XLEN-1:0] st_val,
  output logic [3:0]      dest
);

  logic [XLEN-1:0] op_a, op_m, val2, b_eff, res;
  logic [XLEN:0]   sum;
  logic            cin, arith, cmd_valid, ovf;
  logic [3:0]      flags;

  logic [3:0]      status_q;
  logic            wb_en_q, mem_r_en_q, mem_w_en_q;
  logic [XLEN-1:0] alu_res_q, st_val_q;
  logic [3:0]      dest_q;

  always_comb begin
    case (sel_src1)
      FWD_MEM: op_a = mem_fwd_val;
      FWD_WB:  op_a = wb_fwd_val;
      default: op_a = val_rn_in;
    endcase
    case (sel_src2)
      FWD_MEM: op_m = mem_fwd_val;
      FWD_WB:  op_m = wb_fwd_val;
      default: op_m = val_rm_in;
    endcase
  end

  val2_gen #(
    .XLEN(XLEN)
  ) u_val2_gen (
    .val_rm_i       (op_m),
    .shift_operand_i(shift_operand_in),
    .imm_i          (imm_in),
    .mem_i          (mem_r_en_in | mem_w_en_in),
    .val2_o         (val2)
  );

  // One adder serves all four arithmetic ops: subtraction is A + ~val2 + cin.
  always_comb begin
    b_eff = ((exe_cmd_in == EXE_SUB) || (exe_cmd_in == EXE_SBC)) ? ~val2 : val2;
    case (exe_cmd_in)
      EXE_ADC, EXE_SBC: cin = status_q[STAT_C];
      EXE_SUB:          cin = 1'b1;
      default:          cin = 1'b0;
    endcase
    sum = {1'b0, op_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, cin};
    ovf = (op_a[XLEN-1] == b_eff[XLEN-1]) && (sum[XLEN-1] != op_a[XLEN-1]);

    res       = '0;
    arith     = 1'b0;
    cmd_valid = 1'b1;
    case (exe_cmd_in)
      EXE_MOV: res = val2;
      EXE_MVN: res = ~val2;
      EXE_ADD, EXE_ADC, EXE_SUB, EXE_SBC: begin
        res   = sum[XLEN-1:0];
        arith = 1'b1;
      end
      EXE_AND: res = op_a & val2;
      EXE_ORR: res = op_a | val2;
      EXE_EOR: res = op_a ^ val2;
      default: cmd_valid = 1'b0;
    endcase

    flags         = status_q;
    flags[STAT_N] = res[XLEN-1];
    flags[STAT_Z] = (res == '0);
    if (arith) begin
      flags[STAT_C] = sum[XLEN];
      flags[STAT_V] = ovf;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      status_q   <= '0;
      wb_en_q    <= 1'b0;
      mem_r_en_q <= 1'b0;
      mem_w_en_q <= 1'b0;
      alu_res_q  <= '0;
      st_val_q   <= '0;
      dest_q     <= '0;
    end else if (!freeze) begin
      if (s_in && cmd_valid) status_q <= flags;
      wb_en_q    <= wb_en_in;
      mem_r_en_q <= mem_r_en_in;
      mem_w_en_q <= mem_w_en_in;
      alu_res_q  <= res;
      st_val_q   <= op_m;
      dest_q     <= dest_in;
    end
  end

  assign branch_taken = b_in;
  assign branch_addr  = pc_in + {{(XLEN-26){signed_imm_24_in[23]}}, signed_imm_24_in, 2'b00};
  assign status       = status_q;
  assign wb_en        = wb_en_q;
  assign mem_r_en     = mem_r_en_q;
  assign mem_w_en     = mem_w_en_q;
  assign alu_res      = alu_res_q;
  assign st_val       = st_val_q;
  assign dest         = dest_q;

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: a vector table for ALU/shifter/flag behaviour plus
// hand sequences for freeze, branch, bubble and asynchronous reset.
module tb_exe_stage;
  import arm_pkg::*;

  logic        clk, rst, freeze;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in;
  logic [3:0]  exe_cmd_in, dest_in;
  logic [11:0] shift_operand_in;
  logic [23:0] signed_imm_24_in;
  logic [31:0] pc_in, val_rn_in, val_rm_in, mem_fwd_val, wb_fwd_val;
  logic [1:0]  sel_src1, sel_src2;
  logic        branch_taken, wb_en, mem_r_en, mem_w_en;
  logic [31:0] branch_addr, alu_res, st_val;
  logic [3:0]  status, dest;

  exe_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .b_in(b_in), .s_in(s_in), .imm_in(imm_in), .exe_cmd_in(exe_cmd_in),
    .dest_in(dest_in), .shift_operand_in(shift_operand_in),
    .signed_imm_24_in(signed_imm_24_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
    .val_rm_in(val_rm_in), .sel_src1(sel_src1), .sel_src2(sel_src2),
    .mem_fwd_val(mem_fwd_val), .wb_fwd_val(wb_fwd_val),
    .branch_taken(branch_taken), .branch_addr(branch_addr), .status(status),
    .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .alu_res(alu_res), .st_val(st_val), .dest(dest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic        s, imm, mr, mw;
    logic [11:0] so;
    logic [31:0] rn, rm;
    logic [1:0]  s1, s2;
    logic [31:0] exp_res;
    logic [3:0]  exp_stat;
    logic [31:0] exp_stv;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [31:0] MemFwd = 32'h0000_1000;
  localparam logic [31:0] WbFwd  = 32'h0000_00AA;

  task automatic add(input logic [3:0] cmd, input logic s, input logic imm,
                     input logic mr, input logic mw, input logic [11:0] so,
                     input logic [31:0] rn, input logic [31:0] rm,
                     input logic [1:0] s1, input logic [1:0] s2,
                     input logic [31:0] res, input logic [3:0] stat);
    vec_t v;
    v.cmd = cmd; v.s = s; v.imm = imm; v.mr = mr; v.mw = mw; v.so = so;
    v.rn = rn; v.rm = rm; v.s1 = s1; v.s2 = s2;
    v.exp_res = res; v.exp_stat = stat;
    v.exp_stv = (s2 == 2'b01) ? MemFwd : (s2 == 2'b10) ? WbFwd : rm;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic zero_inputs();
    wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0; b_in = 0; s_in = 0; imm_in = 0;
    exe_cmd_in = 0; dest_in = 0; shift_operand_in = 0; signed_imm_24_in = 0;
    pc_in = 0; val_rn_in = 0; val_rm_in = 0; sel_src1 = 0; sel_src2 = 0;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0;
    zero_inputs();
    mem_fwd_val = MemFwd; wb_fwd_val = WbFwd;

    //   cmd      s  imm mr mw so      rn            rm            s1 s2 res           stat
    add(EXE_ADD, 1, 1, 0, 0, 12'h001, 32'h7FFFFFFF, 32'h00000011, 0, 0, 32'h80000000, 4'b1001);
    add(EXE_MOV, 0, 1, 0, 0, 12'h4FF, 32'h0,        32'h0,        0, 0, 32'hFF000000, 4'b1001);
    add(EXE_MOV, 1, 0, 0, 0, 12'h240, 32'h0,        32'h80000000, 0, 0, 32'hF8000000, 4'b1001);
    add(EXE_SUB, 1, 1, 0, 0, 12'h005, 32'h5,        32'h0,        0, 0, 32'h00000000, 4'b0110);
    add(EXE_SUB, 1, 1, 0, 0, 12'h001, 32'h0,        32'h0,        0, 0, 32'hFFFFFFFF, 4'b1000);
    add(EXE_SBC, 1, 0, 0, 0, 12'h000, 32'h5,        32'h3,        0, 0, 32'h00000001, 4'b0010);
    add(EXE_ADC, 1, 1, 0, 0, 12'h000, 32'hFFFFFFFF, 32'h0,        0, 0, 32'h00000000, 4'b0110);
    add(EXE_AND, 1, 1, 0, 0, 12'h0FF, 32'hF0F0F0F0, 32'h0,        0, 0, 32'h000000F0, 4'b0010);
    add(EXE_ORR, 0, 1, 0, 0, 12'h0F0, 32'h00000F00, 32'h0,        0, 0, 32'h00000FF0, 4'b0010);
    add(EXE_EOR, 1, 0, 0, 0, 12'h820, 32'hFFFF0000, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFF, 4'b1010);
    add(EXE_MVN, 1, 1, 0, 0, 12'h000, 32'h0,        32'h0,        0, 0, 32'hFFFFFFFF, 4'b1010);
    add(4'hF,    1, 1, 0, 0, 12'h001, 32'h1,        32'h0,        0, 0, 32'h00000000, 4'b1010);
    add(EXE_ADD, 0, 0, 0, 1, 12'h008, 32'h0,        32'h00000055, 1, 2, 32'h00001008, 4'b1010);
    add(EXE_MOV, 0, 0, 0, 0, 12'h260, 32'h0,        32'h000000F1, 0, 0, 32'h1000000F, 4'b1010);
    add(EXE_ADD, 1, 0, 0, 0, 12'h080, 32'h1,        32'h40000001, 0, 0, 32'h80000003, 4'b1000);
    add(EXE_ADD, 0, 0, 0, 0, 12'h000, 32'h10,       32'h00001234, 3, 3, 32'h00001244, 4'b1000);
    add(EXE_ADD, 1, 0, 0, 0, 12'h000, 32'h80000000, 32'h80000000, 0, 0, 32'h00000000, 4'b0111);
    add(EXE_ADD, 0, 1, 1, 0, 12'hFFF, 32'h100,      32'h0,        0, 0, 32'h000010FF, 4'b0111);

    repeat (2) @(posedge clk);
    #1;
    check("reset status", {28'd0, status}, 32'd0);
    check("reset alu_res", alu_res, 32'd0);
    check("reset ctrl", {25'd0, wb_en, mem_r_en, mem_w_en, dest}, 32'd0);
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      exe_cmd_in = tbl[i].cmd; s_in = tbl[i].s; imm_in = tbl[i].imm;
      mem_r_en_in = tbl[i].mr; mem_w_en_in = tbl[i].mw; shift_operand_in = tbl[i].so;
      val_rn_in = tbl[i].rn; val_rm_in = tbl[i].rm;
      sel_src1 = tbl[i].s1; sel_src2 = tbl[i].s2;
      wb_en_in = i[0]; dest_in = i[3:0];
      @(posedge clk);
      #1;
      check($sformatf("v%0d alu_res", i), alu_res, tbl[i].exp_res);
      check($sformatf("v%0d status", i), {28'd0, status}, {28'd0, tbl[i].exp_stat});
      check($sformatf("v%0d st_val", i), st_val, tbl[i].exp_stv);
      check($sformatf("v%0d ctrl", i), {25'd0, wb_en, mem_r_en, mem_w_en, dest},
            {25'd0, i[0], tbl[i].mr, tbl[i].mw, i[3:0]});
    end

    // Freeze: a flag-setting ADD must not reach any register for 3 cycles.
    freeze = 1'b1;
    zero_inputs();
    exe_cmd_in = EXE_ADD; s_in = 1; imm_in = 1; shift_operand_in = 12'h001;
    val_rn_in = 32'hFFFFFFFF; dest_in = 4'h9;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("freeze%0d alu_res", c), alu_res, 32'h000010FF);
      check($sformatf("freeze%0d status", c), {28'd0, status}, 32'b0111);
      check($sformatf("freeze%0d ctrl", c), {25'd0, wb_en, mem_r_en, mem_w_en, dest},
            {25'd0, 3'b110, 4'h1});
    end
    freeze = 1'b0;
    @(posedge clk);
    #1;
    check("unfreeze alu_res", alu_res, 32'd0);
    check("unfreeze status", {28'd0, status}, 32'b0110);
    check("unfreeze dest", {28'd0, dest}, 32'h9);

    // Branch target is combinational and independent of the register.
    b_in = 1; pc_in = 32'h100; signed_imm_24_in = 24'hFFFFFF;
    #1;
    check("branch_taken", {31'd0, branch_taken}, 32'd1);
    check("branch_addr back", branch_addr, 32'h000000FC);
    pc_in = 32'h1000; signed_imm_24_in = 24'h000010;
    #1;
    check("branch_addr fwd", branch_addr, 32'h00001040);
    b_in = 0;
    #1;
    check("branch_not_taken", {31'd0, branch_taken}, 32'd0);

    // Flushed bubble: MOV r0 of zero, no writeback, flags untouched.
    zero_inputs();
    @(posedge clk);
    #1;
    check("bubble alu_res", alu_res, 32'd0);
    check("bubble status", {28'd0, status}, 32'b0110);
    check("bubble wb_en", {31'd0, wb_en}, 32'd0);

    exe_cmd_in = EXE_MOV; s_in = 1; imm_in = 1; shift_operand_in = 12'h055; wb_en_in = 1;
    @(posedge clk);
    #1;
    check("pre-reset alu_res", alu_res, 32'h55);
    check("pre-reset status", {28'd0, status}, 32'b0010);

    // Asynchronous reset mid-cycle while frozen.
    freeze = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("async reset status", {28'd0, status}, 32'd0);
    check("async reset alu_res", alu_res, 32'd0);
    check("async reset wb_en", {31'd0, wb_en}, 32'd0);
    rst = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
